// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake on both sides, a persistent carry
// flag for ADC chains, rotates and a one-partial-product-per-cycle multiplier.
module alu_seq #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   input  logic [3:0]           opcode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] y,
   output logic [BUS_WIDTH-1:0] y_hi,
   output logic                 carry_out,
   output logic                 borrow,
   output logic                 zero,
   output logic                 parity,
   output logic                 invalid_op,
   output logic                 busy
);
   localparam int W  = BUS_WIDTH;
   localparam int SW = $clog2(BUS_WIDTH);

   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_INC = 4'd4;
   localparam logic [3:0] OP_DEC = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_ROL = 4'd8;
   localparam logic [3:0] OP_ROR = 4'd9;
   localparam logic [3:0] OP_OR  = 4'd10;
   localparam logic [3:0] OP_XOR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_CLC = 4'd13;

   typedef enum logic {IDLE, MUL} state_t;

   state_t         state;
   logic           cflag;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [SW-1:0]  cnt;

   logic           accept;
   logic [W:0]     wide;
   logic [SW-1:0]  amt;
   logic [2*W-1:0] rot_l;
   logic [2*W-1:0] rot_r;
   logic [W-1:0]   res_y;
   logic           res_c;
   logic           res_b;
   logic           res_inv;
   logic           res_cflag;
   logic [2*W-1:0] acc_next;

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // ready never depends on valid from the same side.
   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state == MUL);

   // Rotates take the matching half of a doubled operand shifted by the amount.
   assign amt   = b[SW-1:0];
   assign rot_l = {a, a} << amt;
   assign rot_r = {a, a} >> amt;

   assign acc_next = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      wide      = '0;
      res_y     = '0;
      res_c     = 1'b0;
      res_b     = 1'b0;
      res_inv   = 1'b0;
      res_cflag = cflag;
      case (opcode)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            res_y = wide[W-1:0]; res_c = wide[W]; res_cflag = wide[W];
         end
         OP_ADC: begin
            wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cflag};
            res_y = wide[W-1:0]; res_c = wide[W]; res_cflag = wide[W];
         end
         OP_INC: begin
            wide = {1'b0, a} + {{W{1'b0}}, 1'b1};
            res_y = wide[W-1:0]; res_c = wide[W]; res_cflag = wide[W];
         end
         OP_SUB: begin
            wide = {1'b0, a} - {1'b0, b};
            res_y = wide[W-1:0]; res_b = wide[W]; res_cflag = wide[W];
         end
         OP_DEC: begin
            wide = {1'b0, a} - {{W{1'b0}}, 1'b1};
            res_y = wide[W-1:0]; res_b = wide[W]; res_cflag = wide[W];
         end
         OP_AND: res_y = a & b;
         OP_OR:  res_y = a | b;
         OP_XOR: res_y = a ^ b;
         OP_NOT: res_y = ~a;
         OP_ROL: res_y = rot_l[2*W-1:W];
         OP_ROR: res_y = rot_r[W-1:0];
         OP_MUL: res_y = '0;
         OP_CLC: res_cflag = 1'b0;
         default: res_inv = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cflag      <= 1'b0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         y          <= '0;
         y_hi       <= '0;
         carry_out  <= 1'b0;
         borrow     <= 1'b0;
         zero       <= 1'b0;
         parity     <= 1'b0;
         invalid_op <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (opcode == OP_MUL) begin
                     state     <= MUL;
                     acc       <= '0;
                     mcand     <= {{W{1'b0}}, a};
                     mplier    <= b;
                     cnt       <= '0;
                     out_valid <= 1'b0;
                  end else begin
                     y          <= res_y;
                     y_hi       <= '0;
                     carry_out  <= res_c;
                     borrow     <= res_b;
                     zero       <= (res_y == '0);
                     parity     <= ^res_y;
                     invalid_op <= res_inv;
                     cflag      <= res_cflag;
                     out_valid  <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // The edge that adds the last partial product also publishes it.
               if (cnt == SW'(W - 1)) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  y          <= acc_next[W-1:0];
                  y_hi       <= acc_next[2*W-1:W];
                  carry_out  <= 1'b0;
                  borrow     <= 1'b0;
                  zero       <= (acc_next == '0);
                  parity     <= ^acc_next[W-1:0];
                  invalid_op <= 1'b0;
                  out_valid  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus randomized ops with random
// consumer backpressure, scored against an arithmetic reference model.
module tb_alu_seq;
   localparam int W  = 8;
   localparam int EW = 2 * W + 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   opcode = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] y, y_hi;
   logic         carry_out, borrow, zero, parity, invalid_op, busy;

   alu_seq #(.BUS_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_hi(y_hi), .carry_out(carry_out), .borrow(borrow), .zero(zero),
      .parity(parity), .invalid_op(invalid_op), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [EW-1:0] exp_q[$];
   int          m_cflag = 0;
   bit          monitor_on = 1'b1;
   bit          done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation rules.
   function automatic logic [EW-1:0] model(input int op, input int av, input int bv);
      int   mask, full, r, hi, c, br, inv, amt;
      logic zr, par;
      mask = (1 << W) - 1;
      r = 0; hi = 0; c = 0; br = 0; inv = 0;
      amt = bv % W;
      case (op)
         1:  begin full = av + bv;           r = full & mask; c = (full >> W) & 1; m_cflag = c; end
         2:  begin full = av + bv + m_cflag; r = full & mask; c = (full >> W) & 1; m_cflag = c; end
         4:  begin full = av + 1;            r = full & mask; c = (full >> W) & 1; m_cflag = c; end
         3:  begin r = (av - bv) & mask; br = (av < bv) ? 1 : 0; m_cflag = br; end
         5:  begin r = (av - 1) & mask;  br = (av == 0) ? 1 : 0; m_cflag = br; end
         6:  r = av & bv;
         7:  r = (~av) & mask;
         8:  r = ((av << amt) | (av >> (W - amt))) & mask;
         9:  r = ((av >> amt) | (av << (W - amt))) & mask;
         10: r = av | bv;
         11: r = av ^ bv;
         12: begin full = av * bv; r = full & mask; hi = (full >> W) & mask; end
         13: m_cflag = 0;
         default: inv = 1;
      endcase
      zr  = (r == 0) && (hi == 0);
      par = ($countones(r) % 2) == 1;
      return {W'(hi), W'(r), c[0], br[0], zr, par, inv[0]};
   endfunction

   task automatic send(input int op, input int av, input int bv);
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      opcode = op[3:0];
      a = av[W-1:0];
      b = bv[W-1:0];
      #1;
      while (!in_ready) begin
         @(negedge clk);
         #1;
         guard++;
         if (guard > 200) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back(model(op, av, bv));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard: every beat the consumer takes must match the oldest expectation.
   always @(negedge clk) begin
      #2;
      if (monitor_on && rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
         else check("result", {y_hi, y, carry_out, borrow, zero, parity, invalid_op},
                    exp_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] held_y;
      int guard;

      // Reset state
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", {y_hi, y}, 0);
      check("rst_flags", {carry_out, borrow, zero, parity, invalid_op, busy}, 0);
      out_ready = 1'b1;
      #9 rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);

      // Carry chain
      send(1, 'hFF, 'h01);
      check("add_y", y, 'h00); check("add_c", carry_out, 1);
      check("add_z", zero, 1); check("add_p", parity, 0);
      send(2, 'h10, 'h20);
      check("adc_y", y, 'h31); check("adc_c", carry_out, 0);
      send(4, 'hFF, 0);
      check("inc_y", y, 'h00); check("inc_c", carry_out, 1);
      send(3, 'h05, 'h07);
      check("sub_y", y, 'hFE); check("sub_b", borrow, 1); check("sub_p", parity, 1);
      send(5, 'h00, 0);
      check("dec_y", y, 'hFF); check("dec_b", borrow, 1);
      send(13, 0, 0);
      check("clc_y", y, 0); check("clc_z", zero, 1);
      send(2, 'h01, 'h01);
      check("clc_adc_y", y, 'h02);

      // Multiplier latency and busy window
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd12; a = 8'hFF; b = 8'hFF;
      #1 check("mul_accept_ready", in_ready, 1);
      exp_q.push_back(model(12, 'hFF, 'hFF));
      @(posedge clk); #1; in_valid = 1'b0;
      for (int e = 2; e <= W + 1; e++) begin
         check("mul_busy", busy, 1);
         check("mul_in_ready", in_ready, 0);
         check("mul_early_valid", out_valid, 0);
         @(posedge clk); #1;
      end
      check("mul_valid", out_valid, 1); check("mul_busy_end", busy, 0);
      check("mul_hi", y_hi, 'hFE); check("mul_lo", y, 'h01); check("mul_z", zero, 0);

      // Rotates
      send(8, 'h81, 'h03); check("rol_y", y, 'h0C);
      send(9, 'h81, 'h09); check("ror_y", y, 'hC0);
      send(8, 'h5A, 'h08); check("rol0_y", y, 'h5A);

      // Invalid opcode leaves the carry alone
      send(1, 'hFF, 'h01);
      send(15, 'h12, 'h34);
      check("inv_flag", invalid_op, 1); check("inv_y", {y_hi, y}, 0); check("inv_z", zero, 1);
      send(2, 'h00, 'h00);
      check("inv_adc_y", y, 'h01);

      // Backpressure then back-to-back XORs
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      send(11, 'h3C, 'h0F);
      fork
         begin
            send(11, 'h01, 'h02);
            send(11, 'h10, 'h20);
            send(11, 'hAA, 'h55);
            send(11, 'hF0, 'h0F);
         end
         begin
            repeat (3) begin
               @(negedge clk); #2;
               check("bp_in_ready", in_ready, 0);
               check("bp_y_stable", y, 'h33);
               check("bp_valid", out_valid, 1);
            end
            @(negedge clk);
            out_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
               #2 check("b2b_valid", out_valid, 1);
               @(negedge clk);
            end
         end
      join

      // Random traffic with random consumer stalls
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send($urandom_range(0, 15), $urandom_range(0, (1 << W) - 1),
                    $urandom_range(0, (1 << W) - 1));
               repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      #3 check("drain_empty", exp_q.size(), 0);

      // Reset in the middle of a multiply
      send(1, 'hFF, 'h01);
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd12; a = 8'h37; b = 8'h59;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_y", {y_hi, y}, 0);
      check("abort_flags", {carry_out, borrow, zero, parity, invalid_op, busy}, 0);
      exp_q.delete();
      m_cflag = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("abort_in_ready", in_ready, 1);
      for (int k = 0; k < W + 2; k++) begin
         @(negedge clk); #2 check("abort_no_stale", out_valid, 0);
      end
      send(2, 'h01, 'h01);
      check("abort_cflag_y", y, 'h02);
      @(negedge clk);
      @(negedge clk);
      #3 check("final_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
